// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: funct3 and ResultSrc encodings, LSU state type and
// alignment helpers used by the memory stage.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU   = 2'b00;
    localparam logic [1:0] RS_MEM   = 2'b01;
    localparam logic [1:0] RS_PC4   = 2'b10;
    localparam logic [1:0] RS_AUIPC = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } lsu_state_e;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [31:0] auipc;
        logic        misaligned;
    } wb_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            F3_H, F3_HU: is_misaligned = a[0];
            F3_W:        is_misaligned = |a;
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    // Force the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] natural_align(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            F3_H, F3_HU: natural_align = {a[1], 1'b0};
            F3_W:        natural_align = 2'b00;
            default:     natural_align = a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (store_i) begin
            case (funct3_i)
                F3_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_W:    be_o = 4'b1111;
                default: be_o = 4'b0000;
            endcase
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    rdata_o = rdata_i;
            F3_BU:   rdata_o = {24'h0, byte_sel};
            F3_HU:   rdata_o = {16'h0, half_sel};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU and MEM/WB register: req/ack data-memory FSM with pipeline stall.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned H/W accesses instead of masking the address.
module mem_stage_lsu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PC_plus4M,
    input  logic [31:0] lAuiPCM,
    input  logic [2:0]  funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PC_plus4W,
    output logic [31:0] lAuiPCW,
    output logic        misalignedW
);

    lsu_state_e  state_q, state_d;
    wb_t         wb_q, wb_d;
    logic        mem_op, is_load, misaligned, stall;
    logic [1:0]  addr_lo;
    logic [31:0] load_data;

    assign mem_op  = MemWriteM | (ResultSrcM == RS_MEM);
    assign is_load = (ResultSrcM == RS_MEM) & ~MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(funct3M, ALUResultM[1:0]);
    assign addr_lo    = ALUResultM[1:0];
`else
    assign misaligned = 1'b0;
    assign addr_lo    = natural_align(funct3M, ALUResultM[1:0]);
`endif

    lsu_align u_align (
        .funct3_i  (funct3M),
        .addr_lo_i (addr_lo),
        .store_i   (MemWriteM),
        .wdata_i   (WriteDataM),
        .rdata_i   (dmem_rdata),
        .be_o      (dmem_be),
        .wdata_o   (dmem_wdata),
        .rdata_o   (load_data)
    );

    assign dmem_req  = (state_q == StAccess);
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};
    // Gated by reset so the front end is released the instant reset asserts.
    assign StallM    = rst_n & stall;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        wb_d    = '0;
        case (state_q)
            StIdle: begin
                if (mem_op && misaligned) begin
                    wb_d.misaligned = 1'b1;
                end else if (mem_op) begin
                    stall   = 1'b1;
                    state_d = StAccess;
                end else begin
                    wb_d.reg_write  = RegWriteM;
                    wb_d.result_src = ResultSrcM;
                    wb_d.rd         = RdM;
                    wb_d.alu_result = ALUResultM;
                    wb_d.pc_plus4   = PC_plus4M;
                    wb_d.auipc      = lAuiPCM;
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    wb_d.reg_write  = RegWriteM;
                    wb_d.result_src = ResultSrcM;
                    wb_d.rd         = RdM;
                    wb_d.alu_result = ALUResultM;
                    wb_d.read_data  = is_load ? load_data : 32'h0;
                    wb_d.pc_plus4   = PC_plus4M;
                    wb_d.auipc      = lAuiPCM;
                    state_d         = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    assign RegWriteW   = wb_q.reg_write;
    assign ResultSrcW  = wb_q.result_src;
    assign RdW         = wb_q.rd;
    assign ALUResultW  = wb_q.alu_result;
    assign ReadDataW   = wb_q.read_data;
    assign PC_plus4W   = wb_q.pc_plus4;
    assign lAuiPCW     = wb_q.auipc;
    assign misalignedW = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PC_plus4M, lAuiPCM;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, RegWriteW, misalignedW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PC_plus4W, lAuiPCW;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          stalls;
    logic        done;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    mem_stage_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .MemWriteM   (MemWriteM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .PC_plus4M   (PC_plus4M),
        .lAuiPCM     (lAuiPCM),
        .funct3M     (funct3M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RdW         (RdW),
        .ALUResultW  (ALUResultW),
        .ReadDataW   (ReadDataW),
        .PC_plus4W   (PC_plus4W),
        .lAuiPCW     (lAuiPCW),
        .misalignedW (misalignedW)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        RdM        = 5'd0;
        PC_plus4M  = 32'h0;
        lAuiPCM    = 32'h0;
        funct3M    = 3'b000;
    endtask

    task automatic set_op(input logic we, input logic [1:0] rs, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [4:0] rd);
        MemWriteM  = we;
        ResultSrcM = rs;
        RegWriteM  = rw;
        ALUResultM = addr;
        WriteDataM = wd;
        funct3M    = f3;
        RdM        = rd;
    endtask

    // Drives one memory op to completion, acking after wait_cyc request cycles.
    task automatic run_access(input int wait_cyc, input logic [31:0] rdata);
        int waited;
        waited = 0;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (dmem_req) begin
                if (waited >= wait_cyc) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    done       = 1'b1;
                end else begin
                    waited++;
                end
            end
            #1;
            if (StallM) stalls++;
            if (done) begin
                cap_we    = dmem_we;
                cap_be    = dmem_be;
                cap_addr  = dmem_addr;
                cap_wdata = dmem_wdata;
            end
            step();
            dmem_ack = 1'b0;
        end
        check_eq("access_done", {31'h0, done}, 32'h1);
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        #2;
        check_eq("rst_req", {31'h0, dmem_req}, 32'h0);
        check_eq("rst_stall", {31'h0, StallM}, 32'h0);
        check_eq("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
        check_eq("rst_alures", ALUResultW, 32'h0);
        check_eq("rst_misal", {31'h0, misalignedW}, 32'h0);
        #10;
        rst_n = 1'b1;
        step();

        // Non-memory op passes straight through
        set_op(1'b0, 2'b00, 1'b1, 32'h1234, 32'h0, 3'b000, 5'd5);
        PC_plus4M = 32'h44;
        #1;
        check_eq("alu_stall", {31'h0, StallM}, 32'h0);
        step();
        check_eq("alu_res", ALUResultW, 32'h1234);
        check_eq("alu_rw", {31'h0, RegWriteW}, 32'h1);
        check_eq("alu_rd", {27'h0, RdW}, 32'd5);
        check_eq("alu_pc4", PC_plus4W, 32'h44);
        check_eq("alu_stall2", {31'h0, StallM}, 32'h0);

        // SB at 0x103
        set_op(1'b1, 2'b00, 1'b0, 32'h103, 32'hAB, 3'b000, 5'd0);
        run_access(0, 32'h0);
        check_eq("sb_be", {28'h0, cap_be}, 32'b1000);
        check_eq("sb_wdata", cap_wdata, 32'hABABABAB);
        check_eq("sb_addr", cap_addr, 32'h100);
        check_eq("sb_we", {31'h0, cap_we}, 32'h1);
        check_eq("sb_stalls", stalls, 32'd1);
        check_eq("sb_rw", {31'h0, RegWriteW}, 32'h0);
        check_eq("sb_rdata", ReadDataW, 32'h0);
        nop();

        // SH at 0x102
        set_op(1'b1, 2'b00, 1'b0, 32'h102, 32'h1234BEEF, 3'b001, 5'd0);
        run_access(1, 32'h0);
        check_eq("sh_be", {28'h0, cap_be}, 32'b1100);
        check_eq("sh_wdata", cap_wdata, 32'hBEEFBEEF);
        check_eq("sh_stalls", stalls, 32'd2);
        nop();

        // LB at 0x201, ack delayed 3 cycles
        set_op(1'b0, 2'b01, 1'b1, 32'h201, 32'h0, 3'b000, 5'd9);
        run_access(3, 32'h0000_8000);
        check_eq("lb_data", ReadDataW, 32'hFFFF_FF80);
        check_eq("lb_stalls", stalls, 32'd4);
        check_eq("lb_be", {28'h0, cap_be}, 32'b1111);
        check_eq("lb_we", {31'h0, cap_we}, 32'h0);
        check_eq("lb_addr", cap_addr, 32'h200);
        check_eq("lb_rw", {31'h0, RegWriteW}, 32'h1);
        check_eq("lb_rd", {27'h0, RdW}, 32'd9);
        check_eq("lb_rs", {30'h0, ResultSrcW}, 32'h1);
        nop();

        set_op(1'b0, 2'b01, 1'b1, 32'h201, 32'h0, 3'b100, 5'd9);
        run_access(0, 32'h0000_8000);
        check_eq("lbu_data", ReadDataW, 32'h0000_0080);
        nop();

        set_op(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 3'b001, 5'd3);
        run_access(0, 32'h8001_0000);
        check_eq("lh_data", ReadDataW, 32'hFFFF_8001);
        nop();

        set_op(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 3'b101, 5'd3);
        run_access(0, 32'h8001_0000);
        check_eq("lhu_data", ReadDataW, 32'h0000_8001);
        nop();

        set_op(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 3'b010, 5'd3);
        run_access(0, 32'h8001_0000);
        check_eq("lw_data", ReadDataW, 32'h8001_0000);
        nop();

        set_op(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 3'b011, 5'd3);
        run_access(0, 32'h8001_0000);
        check_eq("f3_011_data", ReadDataW, 32'h0);
        nop();

        // Reset mid-access, then a late ack must be ignored
        set_op(1'b0, 2'b01, 1'b1, 32'h400, 32'h0, 3'b010, 5'd7);
        step();
        check_eq("ra_req", {31'h0, dmem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ra_req_rst", {31'h0, dmem_req}, 32'h0);
        check_eq("ra_stall_rst", {31'h0, StallM}, 32'h0);
        check_eq("ra_rw_rst", {31'h0, RegWriteW}, 32'h0);
        nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        step();
        check_eq("late_ack_req", {31'h0, dmem_req}, 32'h0);
        check_eq("late_ack_rw", {31'h0, RegWriteW}, 32'h0);
        check_eq("late_ack_rdata", ReadDataW, 32'h0);
        check_eq("late_ack_rd", {27'h0, RdW}, 32'h0);
        dmem_ack = 1'b0;

        // SW at 0x101
        set_op(1'b1, 2'b00, 1'b0, 32'h101, 32'hCAFE_F00D, 3'b010, 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check_eq("swm_stall", {31'h0, StallM}, 32'h0);
        step();
        check_eq("swm_req", {31'h0, dmem_req}, 32'h0);
        check_eq("swm_flag", {31'h0, misalignedW}, 32'h1);
        check_eq("swm_rw", {31'h0, RegWriteW}, 32'h0);
        nop();
        step();
        check_eq("swm_flag_clr", {31'h0, misalignedW}, 32'h0);
`else
        run_access(0, 32'h0);
        check_eq("sw_addr", cap_addr, 32'h100);
        check_eq("sw_be", {28'h0, cap_be}, 32'b1111);
        check_eq("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        check_eq("sw_misal", {31'h0, misalignedW}, 32'h0);
        nop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register and feeding the MEM/WB register. It drives the data-memory request bus with a req/ack handshake, performs byte-lane steering for stores and sign/zero extension for loads, and stalls the front of the pipeline while an access is outstanding. It registers all write-back-bound fields, so it also acts as the MEM/WB pipeline register.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWriteM  in  1  register-file write enable from EX/MEM
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 AUIPC result
- MemWriteM  in  1  store request
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data, unaligned in bits [7:0]/[15:0]
- RdM  in  5  destination register
- PC_plus4M, lAuiPCM  in  32 each  pass-through write-back sources
- funct3M  in  3  access size/sign
- dmem_req  out  1  request valid
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  access complete; dmem_rdata valid same cycle for loads
- dmem_rdata  in  32  raw word read
- StallM  out  1  hold IF/ID/EX and EX/MEM
- RegWriteW  out  1; ResultSrcW  out  2; RdW  out  5
- ALUResultW, ReadDataW, PC_plus4W, lAuiPCW  out  32 each
- misalignedW  out  1  misaligned-access flag (see Configuration)

## Operation
- Memory op = MemWriteM | (ResultSrcM==01). Non-memory ops pass straight into the MEM/WB outputs on the next edge.
- FSM states IDLE, ACCESS.
  - IDLE, memory op present: StallM=1 (combinational), next state ACCESS, MEM/WB loads a bubble (RegWriteW=0, all other W outputs 0).
  - ACCESS: dmem_req=1, bus fields held stable. Without dmem_ack: StallM=1, remain, bubble into MEM/WB. With dmem_ack: StallM=0, capture the extended load data and all M fields into MEM/WB, return to IDLE.
- Inputs must stay stable while StallM=1; the hazard unit enforces this.
- Store lanes, with a=ALUResultM[1:0]:
  - SB: be=0001<<a; wdata = byte replicated ×4.
  - SH: be=0011<<{a[1],0}; wdata = half replicated ×2.
  - SW: be=1111; wdata unchanged.
- Loads: dmem_be=1111. Lane selected by a.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
  - funct3 values 011, 110, 111 return 0.
- ReadDataW is 0 for non-load ops.

## Timing
- Non-memory op: 1-cycle latency; StallM stays 0.
- Memory op: minimum 2 cycles (IDLE detect, then ACCESS with ack in the same cycle). Each ack wait-cycle adds 1 cycle.
- dmem_req is a registered state decode: glitch-free, asserted only in ACCESS.
- A store retires with RegWriteW as supplied, normally 0.
- Reset, including mid-ACCESS: state IDLE; dmem_req, StallM, and all W outputs and misalignedW go to 0 immediately. Any late ack is ignored in IDLE.
- dmem_ack seen in IDLE is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A LH/LHU/SH with a[0]=1, or a LW/SW with a≠00, issues no bus request.
  - One cycle later, MEM/WB receives RegWriteW=0 and misalignedW=1 for one cycle; StallM stays 0.
- Macro undefined:
  - Low address bits are masked to natural alignment (halfword a[0]=0, word a=00) and the access proceeds normally.
  - misalignedW is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - ResultSrc encodings RS_ALU, RS_MEM, RS_PC4, RS_AUIPC;
  - LSU state enum.
- One combinational sub-module, lsu_align: store lane steering, byte enables, and load extraction/extension. The FSM and MEM/WB register stay in the top level.

## Test plan
- Non-memory op: ALUResultM=0x1234, RegWriteM=1, ResultSrcM=00 -> next cycle ALUResultW=0x1234, RegWriteW=1; StallM never asserted.
- SB at addr 0x103, data 0xAB, ack in the first ACCESS cycle -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100; StallM high exactly 1 cycle.
- LB at addr 0x201, rdata 0x0000_8000, ack delayed 3 cycles -> ReadDataW=0xFFFF_FF80; StallM high 4 cycles; LBU on the same data -> 0x0000_0080.
- LH at addr 0x302, rdata 0x8001_0000 -> ReadDataW=0xFFFF_8001; LW -> 0x8001_0000.
- rst_n pulsed low in ACCESS before ack -> dmem_req=0 and StallM=0 at once; a later ack produces no write-back.
- SW at addr 0x101 -> with MEM_MISALIGN_TRAP_EN: no dmem_req, misalignedW=1 for one cycle. Without it: dmem_addr=0x100, be=1111.
